lap_stopwatch: RTL

- Parametrised successor to the two-mode elapsed/split stopwatch.
- Counts mm:ss from a 1 Hz tick enable instead of one count per clock.
- Stores up to LAP_DEPTH lap timestamps in an internal buffer and lets the user recall them after stopping.
- Sits beside the Digital_Watch FSM. Buttons are accepted only while stopwatch_mode_en=1; counting continues in the background while the watch shows other modes.

---
 rtl/lap_stopwatch.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lap_stopwatch.sv
`default_nettype none
// ============================================================================
//  Module   : lap_stopwatch
//  Purpose  : mm:ss stopwatch counted from a 1 Hz tick enable, with a lap
//             buffer of LAP_DEPTH entries that can be recalled after stopping.
//             Buttons are honoured only while stopwatch_mode_en is high;
//             counting carries on in the background regardless.
//  Ports    : clk                 rising-edge system clock
//             rst                 asynchronous active-low reset
//             tick                single-cycle 1 Hz count enable
//             stopwatch_mode_en   gates every button input
//             start_stop / lap / clear / recall   single-cycle button pulses
//             min_out / sec_out   registered display value
//             running / recall_mode               state indicators
//             recall_idx          lap entry being shown in RECALL
//             lap_count           number of laps stored
//             lap_ovf             sticky: lap requested with buffer full
//             rollover            one-cycle pulse on MIN_MAX:SEC_MAX -> 0:00
//  Options  : define LAP_DELTA_EN to store split deltas instead of absolute
//             lap timestamps.
//  Revision : 1.0  initial release
// ============================================================================
module lap_stopwatch #(
    parameter  int LAP_DEPTH  = 4,
    parameter  int CNT_W      = 6,
    parameter  int SEC_MAX    = 59,
    parameter  int MIN_MAX    = 59,
    parameter  int HOLD_TICKS = 3,
    localparam int LAP_W      = $clog2(LAP_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             stopwatch_mode_en,
    input  logic             start_stop,
    input  logic             lap,
    input  logic             clear,
    input  logic             recall,
    output logic [CNT_W-1:0] min_out,
    output logic [CNT_W-1:0] sec_out,
    output logic             running,
    output logic             recall_mode,
    output logic [LAP_W-1:0] recall_idx,
    output logic [LAP_W-1:0] lap_count,
    output logic             lap_ovf,
    output logic             rollover
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_STOP   = 2'd2;
    localparam logic [1:0] S_RECALL = 2'd3;

    // A zero-tick hold still needs a one-bit counter to keep widths legal.
    localparam int HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

    localparam logic [CNT_W-1:0]  C_SEC_MAX = CNT_W'(SEC_MAX);
    localparam logic [CNT_W-1:0]  C_MIN_MAX = CNT_W'(MIN_MAX);
    localparam logic [CNT_W-1:0]  C_ONE     = CNT_W'(1);
    localparam logic [LAP_W-1:0]  C_DEPTH   = LAP_W'(LAP_DEPTH);
    localparam logic [LAP_W-1:0]  C_LAP_ONE = LAP_W'(1);
    localparam logic [HOLD_W-1:0] C_HOLD    = HOLD_W'(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] C_HOLD1   = HOLD_W'(1);

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     min_q, min_d, sec_q, sec_d;
    logic [LAP_W-1:0]     lap_count_q, lap_count_d;
    logic [LAP_W-1:0]     recall_idx_q, recall_idx_d;
    logic                 lap_ovf_q, lap_ovf_d;
    logic                 rollover_q, rollover_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [2*CNT_W-1:0]   hold_val_q;
    logic [2*CNT_W-1:0]   disp_q, disp_d;
    logic [2*CNT_W-1:0]   lap_buf_q [LAP_DEPTH];

    logic                 w_clr, w_ss, w_lap, w_rc;
    logic                 w_count, w_do_clear, w_lap_ok, w_lap_full;
    logic [2*CNT_W-1:0]   w_entry;
    logic [2*CNT_W-1:0]   w_rec_val;

    // ------------------------------------------------------------------
    // Button qualification: gate by mode, then keep only the highest
    // priority press (clear > start_stop > lap > recall).
    // ------------------------------------------------------------------
    always_comb begin
        w_clr = stopwatch_mode_en & clear;
        w_ss  = stopwatch_mode_en & start_stop & ~clear;
        w_lap = stopwatch_mode_en & lap & ~clear & ~start_stop;
        w_rc  = stopwatch_mode_en & recall & ~clear & ~start_stop & ~lap;
    end

    assign w_count    = (state_q == S_RUN) & tick;
    assign w_do_clear = w_clr & ((state_q == S_IDLE) | (state_q == S_STOP));
    assign w_lap_ok   = w_lap & (state_q == S_RUN) & (lap_count_q != C_DEPTH);
    assign w_lap_full = w_lap & (state_q == S_RUN) & (lap_count_q == C_DEPTH);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_ss) state_d = S_RUN;
            end
            S_RUN: begin
                if (w_ss) state_d = S_STOP;
            end
            S_STOP: begin
                if (w_clr)                              state_d = S_IDLE;
                else if (w_ss)                          state_d = S_RUN;
                else if (w_rc && lap_count_q != '0)     state_d = S_RECALL;
            end
            S_RECALL: begin
                if (w_ss) state_d = S_STOP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        running     = (state_q == S_RUN);
        recall_mode = (state_q == S_RECALL);
    end

    // ------------------------------------------------------------------
    // Lap entry value: absolute time, or split delta from the last lap.
    // ------------------------------------------------------------------
`ifdef LAP_DELTA_EN
    localparam logic [CNT_W-1:0] C_SEC_MOD = CNT_W'(SEC_MAX + 1);
    localparam logic [CNT_W-1:0] C_MIN_MOD = CNT_W'(MIN_MAX + 1);

    logic [2*CNT_W-1:0] prev_q, prev_d;
    logic [CNT_W-1:0]   w_prev_min, w_prev_sec, w_dsec, w_dmin;
    logic               w_borrow, w_min_neg;

    // The true delta always fits in CNT_W bits, so modular arithmetic at
    // that width yields the exact result even when the modulus truncates.
    always_comb begin
        w_prev_min = prev_q[2*CNT_W-1:CNT_W];
        w_prev_sec = prev_q[CNT_W-1:0];
        w_borrow   = sec_q < w_prev_sec;
        w_dsec     = sec_q - w_prev_sec;
        if (w_borrow) w_dsec = w_dsec + C_SEC_MOD;
        w_min_neg  = (min_q < w_prev_min) || ((min_q == w_prev_min) && w_borrow);
        w_dmin     = min_q - w_prev_min - {{(CNT_W-1){1'b0}}, w_borrow};
        if (w_min_neg) w_dmin = w_dmin + C_MIN_MOD;
        w_entry    = {w_dmin, w_dsec};
    end

    always_comb begin
        prev_d = prev_q;
        if (w_do_clear)    prev_d = '0;
        else if (w_lap_ok) prev_d = {min_q, sec_q};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev_q <= '0;
        else      prev_q <= prev_d;
    end
`else
    assign w_entry = {min_q, sec_q};
`endif

    // ------------------------------------------------------------------
    // Time, lap bookkeeping and hold counter next-state
    // ------------------------------------------------------------------
    always_comb begin
        min_d      = min_q;
        sec_d      = sec_q;
        rollover_d = 1'b0;
        if (w_do_clear) begin
            min_d = '0;
            sec_d = '0;
        end else if (w_count) begin
            if (sec_q == C_SEC_MAX) begin
                sec_d = '0;
                if (min_q == C_MIN_MAX) begin
                    min_d      = '0;
                    rollover_d = 1'b1;
                end else begin
                    min_d = min_q + C_ONE;
                end
            end else begin
                sec_d = sec_q + C_ONE;
            end
        end
    end

    always_comb begin
        lap_count_d  = lap_count_q;
        recall_idx_d = recall_idx_q;
        lap_ovf_d    = lap_ovf_q;
        if (w_do_clear) begin
            lap_count_d  = '0;
            recall_idx_d = '0;
            lap_ovf_d    = 1'b0;
        end else begin
            if (w_lap_ok)   lap_count_d = lap_count_q + C_LAP_ONE;
            if (w_lap_full) lap_ovf_d   = 1'b1;
            if (state_q == S_STOP && w_rc && lap_count_q != '0)
                recall_idx_d = '0;
            else if (state_q == S_RECALL && w_rc)
                recall_idx_d = (recall_idx_q + C_LAP_ONE == lap_count_q) ?
                               '0 : recall_idx_q + C_LAP_ONE;
        end
    end

    // The hold only lives in RUN; a fresh lap reloads it even on a tick.
    always_comb begin
        hold_d = hold_q;
        if (state_d != S_RUN)           hold_d = '0;
        else if (w_lap_ok)              hold_d = C_HOLD;
        else if (tick && hold_q != '0)  hold_d = hold_q - C_HOLD1;
    end

    // ------------------------------------------------------------------
    // Display source, sampled from current state so it lags by one cycle
    // ------------------------------------------------------------------
    always_comb begin
        w_rec_val = '0;
        for (int i = 0; i < LAP_DEPTH; i++) begin
            if (LAP_W'(i) == recall_idx_q) w_rec_val = lap_buf_q[i];
        end
    end

    always_comb begin
        if (state_q == S_RECALL)                  disp_d = w_rec_val;
        else if (state_q == S_RUN && hold_q != '0) disp_d = hold_val_q;
        else                                      disp_d = {min_q, sec_q};
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            min_q        <= '0;
            sec_q        <= '0;
            lap_count_q  <= '0;
            recall_idx_q <= '0;
            lap_ovf_q    <= 1'b0;
            rollover_q   <= 1'b0;
            hold_q       <= '0;
            hold_val_q   <= '0;
            disp_q       <= '0;
        end else begin
            min_q        <= min_d;
            sec_q        <= sec_d;
            lap_count_q  <= lap_count_d;
            recall_idx_q <= recall_idx_d;
            lap_ovf_q    <= lap_ovf_d;
            rollover_q   <= rollover_d;
            hold_q       <= hold_d;
            disp_q       <= disp_d;
            if (w_lap_ok) hold_val_q <= w_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAP_DEPTH; i++) lap_buf_q[i] <= '0;
        end else if (w_lap_ok) begin
            for (int i = 0; i < LAP_DEPTH; i++) begin
                if (LAP_W'(i) == lap_count_q) lap_buf_q[i] <= w_entry;
            end
        end
    end

    assign min_out    = disp_q[2*CNT_W-1:CNT_W];
    assign sec_out    = disp_q[CNT_W-1:0];
    assign recall_idx = recall_idx_q;
    assign lap_count  = lap_count_q;
    assign lap_ovf    = lap_ovf_q;
    assign rollover   = rollover_q;

endmodule
`default_nettype wire
